// File: rtl/uart_rx_cfg.sv
// UART receiver with a fixed clocks-per-bit rate, configurable word length,
// optional odd/even parity, 1 or 2 stop bits, and parity/framing error flags.
`timescale 1ns/1ps
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_RX_Serial,
  output logic                 o_RX_DV,
  output logic [DATA_BITS-1:0] o_RX_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_ARM   = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO  = IDX_W'(0);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    ARM    = 3'd0,
    IDLE   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  function automatic logic parity_err_f(input logic [DATA_BITS-1:0] data, input logic par_bit);
    logic sum;
    sum = (^data) ^ par_bit;
    if (PARITY_MODE == 1) begin
      return ~sum;
    end else if (PARITY_MODE == 2) begin
      return sum;
    end else begin
      return 1'b0;
    end
  endfunction

  logic                 rx_meta_r;
  logic                 rx_sync_r;
  logic                 rx_s;
  state_t               state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [IDX_W-1:0]     idx_r;
  logic                 stop_idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 par_err_r;
  logic                 frame_err_r;

  assign rx_s = rx_sync_r;

  // Two-flop synchroniser for the asynchronous serial line
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= i_RX_Serial;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Receive state machine with registered outputs
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_r      <= ARM;
      cnt_r        <= CNT_ZERO;
      idx_r        <= IDX_ZERO;
      stop_idx_r   <= 1'b0;
      shift_r      <= {DATA_BITS{1'b0}};
      par_err_r    <= 1'b0;
      frame_err_r  <= 1'b0;
      o_RX_DV      <= 1'b0;
      o_RX_Byte    <= {DATA_BITS{1'b0}};
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Busy       <= 1'b0;
    end else begin
      o_RX_DV <= 1'b0;
      case (state_r)
        // Synchroniser flops still hold their reset 1s for two cycles, so the
        // line must read high once those have flushed before arming.
        ARM: begin
          if (!rx_s) begin
            cnt_r <= CNT_ZERO;
          end else if (cnt_r == CNT_ARM) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        IDLE: begin
          cnt_r <= CNT_ZERO;
          if (!rx_s) begin
            state_r     <= START;
            o_Busy      <= 1'b1;
            par_err_r   <= 1'b0;
            frame_err_r <= 1'b0;
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          if (cnt_r == CNT_MID) begin
            cnt_r <= CNT_ZERO;
            idx_r <= IDX_ZERO;
            if (!rx_s) begin
              state_r <= DATA;
            end else begin
              state_r <= IDLE;
              o_Busy  <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        DATA: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r   <= CNT_ZERO;
            shift_r <= {rx_s, shift_r[DATA_BITS-1:1]};
            if (idx_r == IDX_LAST) begin
              idx_r      <= IDX_ZERO;
              stop_idx_r <= 1'b0;
              state_r    <= (PARITY_MODE != 0) ? PARITY : STOP;
            end else begin
              idx_r <= idx_r + 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        PARITY: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r     <= CNT_ZERO;
            par_err_r <= parity_err_f(shift_r, rx_s);
            state_r   <= STOP;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        STOP: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r <= CNT_ZERO;
            if (stop_idx_r == STOP_LAST) begin
              o_RX_DV      <= 1'b1;
              o_RX_Byte    <= shift_r;
              o_Parity_Err <= par_err_r;
              o_Frame_Err  <= frame_err_r | ~rx_s;
              o_Busy       <= 1'b0;
              stop_idx_r   <= 1'b0;
              state_r      <= rx_s ? IDLE : ARM;
            end else begin
              frame_err_r <= frame_err_r | ~rx_s;
              stop_idx_r  <= stop_idx_r + 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        default: begin
          state_r <= ARM;
          cnt_r   <= CNT_ZERO;
          o_Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three instances (8N1, 8E1, 5O2) fed by
// directed frames; a monitor per instance pops expectations on o_RX_DV.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

  localparam int CPB    = 217;
  localparam int BIT_NS = 8600;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic rst;
  logic rx_a, rx_b, rx_c;

  logic       dv_a, perr_a, ferr_a, busy_a;
  logic [7:0] byte_a;
  logic       dv_b, perr_b, ferr_b, busy_b;
  logic [7:0] byte_b;
  logic       dv_c, perr_c, ferr_c, busy_c;
  logic [4:0] byte_c;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_a (
    .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(rx_a), .o_RX_DV(dv_a), .o_RX_Byte(byte_a),
    .o_Parity_Err(perr_a), .o_Frame_Err(ferr_a), .o_Busy(busy_a));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_b (
    .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(rx_b), .o_RX_DV(dv_b), .o_RX_Byte(byte_b),
    .o_Parity_Err(perr_b), .o_Frame_Err(ferr_b), .o_Busy(busy_b));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .PARITY_MODE(1), .STOP_BITS(2)) u_c (
    .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(rx_c), .o_RX_DV(dv_c), .o_RX_Byte(byte_c),
    .o_Parity_Err(perr_c), .o_Frame_Err(ferr_c), .o_Busy(busy_c));

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int id, input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    e.data = d;
    e.perr = pe;
    e.ferr = fe;
    case (id)
      0:       q_a.push_back(e);
      1:       q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  task automatic score(input int id, input logic [8:0] d, input logic pe, input logic fe, input logic bz);
    exp_t e;
    int   n;
    case (id)
      0:       n = q_a.size();
      1:       n = q_b.size();
      default: n = q_c.size();
    endcase
    total++;
    if (n == 0) begin
      bad++;
      $display("FAIL dv_unexpected[%0d]: got o_RX_DV=1 byte=%0h with no frame pending", id, d);
    end else begin
      case (id)
        0:       e = q_a.pop_front();
        1:       e = q_b.pop_front();
        default: e = q_c.pop_front();
      endcase
      check($sformatf("byte[%0d]", id), 32'(d), 32'(e.data));
      check($sformatf("parity_err[%0d]", id), 32'(pe), 32'(e.perr));
      check($sformatf("frame_err[%0d]", id), 32'(fe), 32'(e.ferr));
      check($sformatf("busy_at_dv[%0d]", id), 32'(bz), 32'd0);
    end
  endtask

  always @(negedge clk) if (dv_a === 1'b1) score(0, {1'b0, byte_a}, perr_a, ferr_a, busy_a);
  always @(negedge clk) if (dv_b === 1'b1) score(1, {1'b0, byte_b}, perr_b, ferr_b, busy_b);
  always @(negedge clk) if (dv_c === 1'b1) score(2, {4'b0000, byte_c}, perr_c, ferr_c, busy_c);

  task automatic drive(input int id, input logic v);
    case (id)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  // par < 0 means no parity bit; s2 is used only when nstop == 2
  task automatic send(input int id, input logic [8:0] d, input int nbits, input int par,
                      input logic s1, input logic s2, input int nstop);
    drive(id, 1'b0);
    #(BIT_NS);
    for (int i = 0; i < nbits; i++) begin
      drive(id, d[i]);
      #(BIT_NS);
    end
    if (par >= 0) begin
      drive(id, par[0]);
      #(BIT_NS);
    end
    drive(id, s1);
    #(BIT_NS);
    if (nstop == 2) begin
      drive(id, s2);
      #(BIT_NS);
    end
    drive(id, 1'b1);
  endtask

  task automatic idle_bits(input int n);
    #(n * BIT_NS);
  endtask

  task automatic pulse_reset_and_check();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_dv", 32'(dv_a), 32'd0);
    check("rst_byte", 32'(byte_a), 32'd0);
    check("rst_perr", 32'(perr_a), 32'd0);
    check("rst_ferr", 32'(ferr_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    rx_a = 1'b1;
    rx_b = 1'b1;
    rx_c = 1'b1;
    repeat (3) @(negedge clk);
    check("init_dv", 32'(dv_a), 32'd0);
    check("init_byte", 32'(byte_a), 32'd0);
    check("init_perr", 32'(perr_a), 32'd0);
    check("init_ferr", 32'(ferr_a), 32'd0);
    check("init_busy", 32'(busy_a), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Plain 8N1 frame
    push(0, 9'h037, 1'b0, 1'b0);
    send(0, 9'h037, 8, -1, 1'b1, 1'b1, 1);
    idle_bits(2);

    // Even parity: 0x37 has five ones, so a parity bit of 1 is correct
    push(1, 9'h037, 1'b0, 1'b0);
    send(1, 9'h037, 8, 1, 1'b1, 1'b1, 1);
    idle_bits(2);
    push(1, 9'h037, 1'b1, 1'b0);
    send(1, 9'h037, 8, 0, 1'b1, 1'b1, 1);
    idle_bits(2);

    // Stop bit low, then a clean frame
    push(0, 9'h0A5, 1'b0, 1'b1);
    send(0, 9'h0A5, 8, -1, 1'b0, 1'b1, 1);
    idle_bits(2);
    push(0, 9'h05A, 1'b0, 1'b0);
    send(0, 9'h05A, 8, -1, 1'b1, 1'b1, 1);
    idle_bits(2);

    // 50-clock glitch rejected at the start-bit midpoint
    rx_a = 1'b0;
    #(25 * 40);
    check("glitch_busy_high", 32'(busy_a), 32'd1);
    #(25 * 40);
    rx_a = 1'b1;
    idle_bits(1);
    check("glitch_busy_low", 32'(busy_a), 32'd0);

    // Back-to-back frames, no idle gap
    push(0, 9'h055, 1'b0, 1'b0);
    push(0, 9'h0AA, 1'b0, 1'b0);
    send(0, 9'h055, 8, -1, 1'b1, 1'b1, 1);
    send(0, 9'h0AA, 8, -1, 1'b1, 1'b1, 1);
    idle_bits(2);

    // Reset in the middle of data bit 4 discards the frame
    rx_a = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx_a = i[0];
      #(BIT_NS);
    end
    rx_a = 1'b1;
    #(BIT_NS / 2);
    pulse_reset_and_check();
    #(BIT_NS / 2);
    idle_bits(3);
    push(0, 9'h0C3, 1'b0, 1'b0);
    send(0, 9'h0C3, 8, -1, 1'b1, 1'b1, 1);
    idle_bits(2);

    // Line held low through reset: nothing until the line returns high
    rx_a = 1'b0;
    #(BIT_NS);
    pulse_reset_and_check();
    idle_bits(12);
    check("low_thru_reset_busy", 32'(busy_a), 32'd0);
    rx_a = 1'b1;
    idle_bits(2);
    push(0, 9'h03C, 1'b0, 1'b0);
    send(0, 9'h03C, 8, -1, 1'b1, 1'b1, 1);
    idle_bits(2);

    // Break: one framing-error frame of zeros, then silence while low
    push(0, 9'h000, 1'b0, 1'b1);
    rx_a = 1'b0;
    idle_bits(30);
    check("break_busy", 32'(busy_a), 32'd0);
    rx_a = 1'b1;
    idle_bits(2);
    push(0, 9'h081, 1'b0, 1'b0);
    send(0, 9'h081, 8, -1, 1'b1, 1'b1, 1);
    idle_bits(2);

    // 5 data bits, odd parity, 2 stop bits: 0x1F has five ones, parity 0 is correct
    push(2, 9'h01F, 1'b0, 1'b0);
    send(2, 9'h01F, 5, 0, 1'b1, 1'b1, 2);
    idle_bits(2);
    push(2, 9'h01F, 1'b0, 1'b1);
    send(2, 9'h01F, 5, 0, 1'b1, 1'b0, 2);
    idle_bits(3);

    check("pending_a", 32'(q_a.size()), 32'd0);
    check("pending_b", 32'(q_b.size()), 32'd0);
    check("pending_c", 32'(q_c.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver for single-line asynchronous serial input at a fixed clocks-per-bit rate. It supports configurable data length, optional odd/even parity and 1 or 2 stop bits. It adds input synchronisation, start-bit glitch rejection, parity and framing error flags, and a busy indicator. It sits between the board RX pin and the byte-level consumer, which may be a command decoder or a FIFO.

Parameters:
CLKS_PER_BIT, 217, system clocks per serial bit (25 MHz / 115200); legal range >= 4
DATA_BITS, 8, data bits per frame, LSB first; legal 5..9
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits checked; legal 1 or 2

Ports:
i_Clock  in  1  system clock; all logic on rising edge
i_Reset  in  1  synchronous reset, active-high
i_RX_Serial  in  1  asynchronous serial line; idles high
o_RX_DV  out  1  one-cycle pulse; frame complete; o_RX_Byte and error flags valid
o_RX_Byte  out  DATA_BITS  last received data word; held until next o_RX_DV
o_Parity_Err  out  1  parity mismatch on last frame; 0 when PARITY_MODE = 0; held with o_RX_Byte
o_Frame_Err  out  1  a stop bit sampled low on last frame; held with o_RX_Byte
o_Busy  out  1  high in every state except IDLE and ARM

Behaviour:
- Reset and clocking: one clock (i_Clock). Reset is synchronous, active-high (i_Reset).
- Input path: 2-flop synchroniser on i_RX_Serial; both flops reset to 1. All decisions use the synchronised bit rx_s.
- Reset values: o_RX_DV = 0, o_RX_Byte = 0, o_Parity_Err = 0, o_Frame_Err = 0, o_Busy = 0. State = ARM; counters and shift register = 0.
- Reset mid-frame: the partial frame is discarded and no o_RX_DV is produced.
- Bit counter: counts 0..CLKS_PER_BIT-1. Its width is clog2(CLKS_PER_BIT). It clears on every state change.
- ARM: wait for rx_s = 1, then go to IDLE. This prevents a line held low through reset from being taken as a start bit.
- IDLE: rx_s = 0 -> START, counter = 0.
- START:
  - At count = (CLKS_PER_BIT-1)/2 (integer division), sample rx_s.
  - If rx_s = 0, go to DATA and clear the counter. This re-centres sampling on mid-bit.
  - If rx_s = 1, the low was a glitch: go to IDLE with no output.
- DATA:
  - At count = CLKS_PER_BIT-1, shift rx_s into bit index idx (LSB first).
  - When idx = DATA_BITS-1 is sampled, go to PARITY if PARITY_MODE != 0, else to STOP.
- PARITY:
  - At count = CLKS_PER_BIT-1, sample the parity bit.
  - Even mode: error if XOR(data, parity bit) != 0.
  - Odd mode: error if XOR(data, parity bit) != 1.
  - Latch the result internally.
- STOP:
  - At count = CLKS_PER_BIT-1, sample the stop bit; any stop bit = 0 sets the frame error.
  - After the STOP_BITS-th sample, in the same cycle:
    - register o_RX_Byte, o_Parity_Err and o_Frame_Err;
    - pulse o_RX_DV for exactly 1 cycle;
    - return to IDLE, or to ARM if the final stop sample was 0.
- Output timing: o_RX_DV rises on the clock edge after the mid-point sample of the last stop bit, plus 2 cycles of synchroniser delay.
- Back-to-back frames: the return to IDLE happens half a bit before the nominal stop-bit end. A start bit immediately after the stop bit is therefore caught with no idle gap required.
- Errored frames: still deliver o_RX_DV and the data. The consumer decides whether to drop them. Flags change only on o_RX_DV.
- Break (line held low): gives one frame with o_Frame_Err = 1, then ARM. No further o_RX_DV until the line returns high.
- Total counter overflow is impossible by construction. The bit index width is clog2(DATA_BITS+1).

Test Plan:
- Defaults (CLKS_PER_BIT = 217, 40 ns clock): send 0x37 8N1 with 8600 ns bits -> exactly one o_RX_DV; o_RX_Byte = 0x37; both error flags 0; o_Busy falls within 1 cycle of o_RX_DV.
- PARITY_MODE = 2: send 0x37 with parity 1 -> o_Parity_Err = 0. Resend with parity 0 -> o_RX_Byte = 0x37, o_Parity_Err = 1.
- Stop bit driven 0 on 0xA5, then line high -> o_RX_DV with o_RX_Byte = 0xA5 and o_Frame_Err = 1. Next 0x5A frame -> o_Frame_Err = 0.
- Low glitch of 50 clocks on idle line -> no o_RX_DV, o_Busy returns to 0. Then back-to-back 0x55, 0xAA with zero idle gap -> two o_RX_DV pulses with 0x55 then 0xAA.
- Assert i_Reset for 1 cycle during data bit 4 of a frame -> no o_RX_DV for that frame; outputs 0. Next full frame 0xC3 is received correctly. Line held low through reset -> nothing received until the line goes high.
- DATA_BITS = 5, STOP_BITS = 2, PARITY_MODE = 1: send 0x1F with parity 0 and both stops high -> o_RX_Byte = 0x1F with no errors. Second stop bit low -> o_Frame_Err = 1.
